// File: rtl/dram_request_scheduler.sv
// Timestamped DRAM request FIFO with in-order release, per-bank open-row
// classification (HIT/EMPTY/MISS) and saturating per-class statistics.
module dram_request_scheduler #(
    parameter int ADDR_WIDTH  = 36,
    parameter int MEMOP_WIDTH = 2,
    parameter int TIME_WIDTH  = 12,
    parameter int CYCLE_WIDTH = 64,
    parameter int QUEUE_DEPTH = 16,
    parameter int BG_WIDTH    = 2,
    parameter int BANK_WIDTH  = 2,
    parameter int ROW_WIDTH   = 15,
    parameter int COL_WIDTH   = 11,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [CYCLE_WIDTH-1:0]                     cycle,
    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic [TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH-1:0] req_data,
    output logic                                       cmd_valid,
    input  logic                                       cmd_ready,
    output logic [MEMOP_WIDTH-1:0]                     cmd_op,
    output logic [BG_WIDTH-1:0]                        cmd_bg,
    output logic [BANK_WIDTH-1:0]                      cmd_bank,
    output logic [ROW_WIDTH-1:0]                       cmd_row,
    output logic [COL_WIDTH-1:0]                       cmd_col,
    output logic [1:0]                                 cmd_policy,
    output logic                                       cmd_diff_bg,
    output logic [$clog2(QUEUE_DEPTH):0]               queue_count,
    output logic                                       idle,
    output logic [STAT_WIDTH-1:0]                      hit_count,
    output logic [STAT_WIDTH-1:0]                      empty_count,
    output logic [STAT_WIDTH-1:0]                      miss_count
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = BG_WIDTH + BANK_WIDTH;
    localparam int NB = 1 << IW;
    localparam logic [1:0] POL_HIT = 2'd0, POL_EMPTY = 2'd1, POL_MISS = 2'd2;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]  t;
        logic [MEMOP_WIDTH-1:0] op;
        logic [BG_WIDTH-1:0]    bg;
        logic [BANK_WIDTH-1:0]  bank;
        logic [ROW_WIDTH-1:0]   row;
        logic [COL_WIDTH-1:0]   col;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_ISSUE} state_t;

    entry_t                in_e, head;
    entry_t                mem [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, cnt_next;
    logic                  push, load, hs, head_due, next_valid;
    logic [NB-1:0]         open_vld;
    logic [ROW_WIDTH-1:0]  open_row [NB];
    logic [IW-1:0]         cmd_idx, head_idx;
    logic                  vld_eff;
    logic [ROW_WIDTH-1:0]  row_eff;
    logic [1:0]            policy_next;
    logic [BG_WIDTH-1:0]   prev_bg;
    logic                  prev_bg_vld;
    state_t                state;
    logic                  unused_lsbs;

    // Address fields are taken MSB-first; any leftover low address bits are dropped.
    assign in_e.t    = req_data[ADDR_WIDTH+MEMOP_WIDTH +: TIME_WIDTH];
    assign in_e.op   = req_data[ADDR_WIDTH +: MEMOP_WIDTH];
    assign in_e.bg   = req_data[ADDR_WIDTH-1 -: BG_WIDTH];
    assign in_e.bank = req_data[ADDR_WIDTH-BG_WIDTH-1 -: BANK_WIDTH];
    assign in_e.row  = req_data[ADDR_WIDTH-IW-1 -: ROW_WIDTH];
    assign in_e.col  = req_data[ADDR_WIDTH-IW-ROW_WIDTH-1 -: COL_WIDTH];
    assign unused_lsbs = ^req_data;

    assign req_ready   = count < CW'(QUEUE_DEPTH);
    assign push        = req_valid && req_ready;
    assign head        = mem[rd_ptr];
    assign head_due    = CYCLE_WIDTH'(head.t) <= cycle;
    assign hs          = cmd_valid && cmd_ready;
    assign load        = (!cmd_valid || cmd_ready) && (count != '0) && head_due;
    assign next_valid  = load || (cmd_valid && !cmd_ready);
    assign cnt_next    = count + CW'(push) - CW'(load);
    assign queue_count = count;
    assign idle        = (state == S_EMPTY);
    assign cmd_idx     = {cmd_bg, cmd_bank};
    assign head_idx    = {head.bg, head.bank};

    // A handshake on the load edge opens its row before the new head is classified.
    always_comb begin
        vld_eff = open_vld[head_idx];
        row_eff = open_row[head_idx];
        if (hs && cmd_idx == head_idx) begin
            vld_eff = 1'b1;
            row_eff = cmd_row;
        end
        if (!vld_eff)               policy_next = POL_EMPTY;
        else if (row_eff == head.row) policy_next = POL_HIT;
        else                        policy_next = POL_MISS;
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_e;
        if (hs)   open_row[cmd_idx] <= cmd_row;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= S_EMPTY;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_bg      <= '0;
            cmd_bank    <= '0;
            cmd_row     <= '0;
            cmd_col     <= '0;
            cmd_policy  <= '0;
            cmd_diff_bg <= 1'b0;
            open_vld    <= '0;
            prev_bg     <= '0;
            prev_bg_vld <= 1'b0;
            hit_count   <= '0;
            empty_count <= '0;
            miss_count  <= '0;
        end else begin
            count     <= cnt_next;
            cmd_valid <= next_valid;
            if (next_valid)           state <= S_ISSUE;
            else if (cnt_next == '0)  state <= S_EMPTY;
            else                      state <= S_WAIT;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (load) rd_ptr <= rd_ptr + PW'(1);
            if (hs) begin
                open_vld[cmd_idx] <= 1'b1;
                case (cmd_policy)
                    POL_HIT:   if (hit_count   != '1) hit_count   <= hit_count   + STAT_WIDTH'(1);
                    POL_EMPTY: if (empty_count != '1) empty_count <= empty_count + STAT_WIDTH'(1);
                    POL_MISS:  if (miss_count  != '1) miss_count  <= miss_count  + STAT_WIDTH'(1);
                    default: ;
                endcase
            end
            if (load) begin
                cmd_op      <= head.op;
                cmd_bg      <= head.bg;
                cmd_bank    <= head.bank;
                cmd_row     <= head.row;
                cmd_col     <= head.col;
                cmd_policy  <= policy_next;
                cmd_diff_bg <= prev_bg_vld && (head.bg != prev_bg);
                prev_bg     <= head.bg;
                prev_bg_vld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dram_request_scheduler.sv
// Scoreboard bench: expected commands are queued at enqueue time from an
// in-order open-row model and popped as handshakes complete.
module tb_dram_request_scheduler;
    localparam int NB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] cyc = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [49:0] req_data = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op, cmd_bg, cmd_bank, cmd_policy;
    logic [14:0] cmd_row;
    logic [10:0] cmd_col;
    logic        cmd_diff_bg;
    logic [4:0]  queue_count;
    logic        idle;
    logic [31:0] hit_count, empty_count, miss_count;

    dram_request_scheduler dut (
        .clock(clock), .reset(reset), .cycle(cyc),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_policy(cmd_policy),
        .cmd_diff_bg(cmd_diff_bg), .queue_count(queue_count), .idle(idle),
        .hit_count(hit_count), .empty_count(empty_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op, bg, bank, pol;
        logic [14:0] row;
        logic [10:0] col;
        logic        diff;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0, errors = 0;
    logic        m_vld [NB];
    logic [14:0] m_row [NB];
    logic        m_prev_vld;
    logic [1:0]  m_prev_bg;
    int          exp_hit, exp_empty, exp_miss;

    always @(negedge clock) begin
        if (!reset && cmd_valid && cmd_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected got bg=%0d bank=%0d row=%0h with nothing expected", cmd_bg, cmd_bank, cmd_row);
            end else begin
                mon_e = sb.pop_front();
                if ({cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_policy, cmd_diff_bg} !==
                    {mon_e.op, mon_e.bg, mon_e.bank, mon_e.row, mon_e.col, mon_e.pol, mon_e.diff}) begin
                    errors++;
                    $display("FAIL cmd_fields got op=%0d bg=%0d bank=%0d row=%0h col=%0h pol=%0d diff=%0d exp op=%0d bg=%0d bank=%0d row=%0h col=%0h pol=%0d diff=%0d",
                             cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_policy, cmd_diff_bg,
                             mon_e.op, mon_e.bg, mon_e.bank, mon_e.row, mon_e.col, mon_e.pol, mon_e.diff);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task step;
        @(posedge clock);
        #1;
        cyc = cyc + 1;
    endtask

    task model_reset;
        for (int i = 0; i < NB; i++) m_vld[i] = 1'b0;
        m_prev_vld = 1'b0;
        m_prev_bg  = '0;
        exp_hit = 0; exp_empty = 0; exp_miss = 0;
        sb.delete();
    endtask

    task apply_reset;
        reset = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task push(input logic [11:0] t, input logic [1:0] op, input logic [1:0] bg,
              input logic [1:0] bank, input logic [14:0] row, input logic [10:0] col);
        exp_t       e;
        logic [3:0] idx;
        bit         ok;
        ok = 1'b0;
        req_data  = {t, op, bg, bank, row, col, 6'h00};
        req_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (req_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_accept got req_ready=0 for 200 cycles exp acceptance");
        end else begin
            idx    = {bg, bank};
            e.op   = op; e.bg = bg; e.bank = bank; e.row = row; e.col = col;
            e.pol  = !m_vld[idx] ? 2'd1 : (m_row[idx] == row ? 2'd0 : 2'd2);
            e.diff = m_prev_vld && (bg != m_prev_bg);
            case (e.pol)
                2'd0:    exp_hit++;
                2'd1:    exp_empty++;
                default: exp_miss++;
            endcase
            m_vld[idx] = 1'b1;
            m_row[idx] = row;
            m_prev_vld = 1'b1;
            m_prev_bg  = bg;
            sb.push_back(e);
        end
    endtask

    task test_reset;
        cmd_ready = 1'b0;
        apply_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({cmd_valid, cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_policy, cmd_diff_bg,
             queue_count, hit_count, empty_count, miss_count} !== '0) begin
            errors++;
            $display("FAIL reset_zero got valid=%0d qc=%0d stats=%0d/%0d/%0d exp all 0",
                     cmd_valid, queue_count, hit_count, empty_count, miss_count);
        end
        checks++;
        if ({req_ready, idle} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready_idle got %b%b exp 11", req_ready, idle);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task test_single_read;
        cyc = 0;
        cmd_ready = 1'b1;
        push(12'd5, 2'd0, 2'd1, 2'd2, 15'h10, 11'h3);
        for (int k = 0; k < 20 && !cmd_valid; k++) step();
        checks++;
        if (cyc !== 64'd6) begin
            errors++;
            $display("FAIL single_latency got cmd_valid at cycle %0d exp 6", cyc);
        end
        checks++;
        if ({cmd_policy, cmd_diff_bg} !== 3'b010) begin
            errors++;
            $display("FAIL single_class got pol=%0d diff=%0d exp pol=1 diff=0", cmd_policy, cmd_diff_bg);
        end
        step();
        checks++;
        if (empty_count !== 32'd1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_stats got empty=%0d valid=%0d exp empty=1 valid=0", empty_count, cmd_valid);
        end
    endtask

    task test_back_to_back;
        int n;
        cmd_ready = 1'b0;
        push(12'd0, 2'd1, 2'd2, 2'd3, 15'h10, 11'h1);
        push(12'd0, 2'd1, 2'd2, 2'd3, 15'h10, 11'h2);
        push(12'd0, 2'd0, 2'd2, 2'd3, 15'h20, 11'h3);
        cmd_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (!cmd_valid) break;
            n++;
            step();
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL b2b_run got %0d consecutive cycles exp 3", n);
        end
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1 || empty_count !== 32'(exp_empty)) begin
            errors++;
            $display("FAIL b2b_stats got hit=%0d miss=%0d empty=%0d exp 1 1 %0d", hit_count, miss_count, empty_count, exp_empty);
        end
    endtask

    task test_fill;
        logic [34:0] snap;
        bit          bad;
        cmd_ready = 1'b0;
        for (int i = 0; i < 17; i++)
            push(12'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 15'($urandom_range(0, 3)), 11'(i));
        checks++;
        if (queue_count !== 5'd16 || req_ready !== 1'b0 || cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got qc=%0d ready=%0d valid=%0d exp 16 0 1", queue_count, req_ready, cmd_valid);
        end
        snap = {cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_policy, cmd_diff_bg};
        req_data  = {12'd0, 2'd3, 2'd0, 2'd0, 15'h7f, 11'h7ff, 6'h00};
        req_valid = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (req_ready !== 1'b0 || queue_count !== 5'd16 || cmd_valid !== 1'b1 ||
                {cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_policy, cmd_diff_bg} !== snap) bad = 1'b1;
        end
        req_valid = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold got qc=%0d ready=%0d cmd=%h exp qc=16 ready=0 cmd=%h", queue_count, req_ready,
                     {cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_policy, cmd_diff_bg}, snap);
        end
        // While full, a pop on the same edge must not let the waiting request in.
        cmd_ready = 1'b1;
        push(12'd0, 2'd2, 2'd3, 2'd1, 15'h55, 11'h11);
        checks++;
        if (queue_count !== 5'd15) begin
            errors++;
            $display("FAIL full_pop_refuse got qc=%0d exp 15", queue_count);
        end
        repeat (16) step();
        checks++;
        if (cmd_valid !== 1'b0 || queue_count !== 5'd0 || sb.size() != 0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL drain_rate got valid=%0d qc=%0d pending=%0d idle=%0d exp 0 0 0 1", cmd_valid, queue_count, sb.size(), idle);
        end
    endtask

    task test_not_due;
        cmd_ready = 1'b1;
        cyc = 50;
        push(12'd100, 2'd0, 2'd0, 2'd1, 15'h1, 11'h0);
        push(12'd3, 2'd1, 2'd3, 2'd0, 15'h2, 11'h0);
        for (int k = 0; k < 200 && !cmd_valid; k++) step();
        checks++;
        if (cyc !== 64'd101) begin
            errors++;
            $display("FAIL not_due_block got cmd_valid at cycle %0d exp 101", cyc);
        end
        repeat (3) step();
        checks++;
        if (sb.size() != 0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL not_due_drain got pending=%0d idle=%0d exp 0 1", sb.size(), idle);
        end
    endtask

    task test_diff_bg;
        apply_reset();
        cmd_ready = 1'b1;
        push(12'd0, 2'd0, 2'd0, 2'd0, 15'h5, 11'h0);
        push(12'd0, 2'd0, 2'd1, 2'd1, 15'h6, 11'h0);
        push(12'd0, 2'd0, 2'd1, 2'd2, 15'h7, 11'h0);
        repeat (4) step();
        checks++;
        if (sb.size() != 0 || empty_count !== 32'd3) begin
            errors++;
            $display("FAIL diff_bg_drain got pending=%0d empty=%0d exp 0 3", sb.size(), empty_count);
        end
    endtask

    task test_reset_mid;
        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(12'd0, 2'd1, 2'd1, 2'd1, 15'(i), 11'h0);
        checks++;
        if (cmd_valid !== 1'b1 || queue_count !== 5'd5) begin
            errors++;
            $display("FAIL mid_setup got valid=%0d qc=%0d exp 1 5", cmd_valid, queue_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || queue_count !== 5'd0 || idle !== 1'b1 ||
            {hit_count, empty_count, miss_count} !== '0) begin
            errors++;
            $display("FAIL mid_reset got valid=%0d qc=%0d idle=%0d stats=%0d/%0d/%0d exp 0 0 1 0/0/0",
                     cmd_valid, queue_count, idle, hit_count, empty_count, miss_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        cmd_ready = 1'b1;
        push(12'd0, 2'd2, 2'd0, 2'd0, 15'h5, 11'h0);
        repeat (3) step();
        checks++;
        if (empty_count !== 32'd1 || hit_count !== 32'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL mid_after got empty=%0d hit=%0d pending=%0d exp 1 0 0", empty_count, hit_count, sb.size());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_fill();
        test_not_due();
        test_diff_bg();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_pending got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
